// File: rtl/drac_pkg.sv
// Shared types and constants for the iterative shift-add multiplier.
package drac_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } mul_op_t;

  localparam int MUL_ITER_64 = 64;
  localparam int MUL_ITER_32 = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mul_state_t;

  function automatic logic [63:0] mul_magnitude(input logic [63:0] value, input logic is_neg);
    return is_neg ? (~value + 64'd1) : value;
  endfunction

endpackage

// File: rtl/mul_iter_unit.sv
// Radix-2 iterative multiplier: one shift-add step per cycle on operand
// magnitudes, followed by a sign fix-up of the 128-bit product.
module mul_iter_unit
  import drac_pkg::*;
(
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        kill_mul_i,
  input  logic        request_i,
  input  logic        int_32_i,
  input  mul_op_t     op_i,
  input  logic [63:0] src1_i,
  input  logic [63:0] src2_i,
  output logic [63:0] result_o,
  output logic        stall_o,
  output logic        done_tick_o
);

  mul_state_t  r_state;
  mul_state_t  w_next_state;
  logic [63:0] r_mcand;
  logic [63:0] r_hi;
  logic [63:0] r_lo;
  logic [6:0]  r_count;
  logic        r_neg;
  logic        r_int32;
  mul_op_t     r_op;

  logic        w_accept;
  logic        w_sign1;
  logic        w_sign2;
  logic [63:0] w_mag1;
  logic [63:0] w_mag2;
  logic [64:0] w_sum;
  logic        w_stall;
  logic        w_done;
  logic [63:0] w_result;

  assign w_accept = (r_state == IDLE) && request_i && !kill_mul_i;
  assign w_sign1  = !int_32_i && ((op_i == MULH) || (op_i == MULHSU)) && src1_i[63];
  assign w_sign2  = !int_32_i && (op_i == MULH) && src2_i[63];
  assign w_mag1   = int_32_i ? {32'd0, src1_i[31:0]} : mul_magnitude(src1_i, w_sign1);
  assign w_mag2   = int_32_i ? {32'd0, src2_i[31:0]} : mul_magnitude(src2_i, w_sign2);

  // The multiplier sits in r_lo and is consumed from bit 0 while the partial
  // product enters from the top; the 65-bit sum keeps the carry for the shift.
  assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : 65'd0);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_stall      = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state = OP;
          w_stall      = 1'b1;
        end
      end
      OP: begin
        if (kill_mul_i) begin
          w_next_state = IDLE;
        end else begin
          w_stall = 1'b1;
          if (r_count == 7'd1) begin
            w_next_state = FIX;
          end
        end
      end
      FIX: begin
        if (kill_mul_i) begin
          w_next_state = IDLE;
        end else begin
          w_stall      = 1'b1;
          w_next_state = DONE;
        end
      end
      DONE: begin
        w_next_state = IDLE;
        w_done       = !kill_mul_i;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_mcand <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_count <= '0;
      r_neg   <= 1'b0;
      r_int32 <= 1'b0;
      r_op    <= MUL;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_mcand <= w_mag1;
            r_hi    <= '0;
            r_lo    <= w_mag2;
            r_count <= int_32_i ? 7'(MUL_ITER_32) : 7'(MUL_ITER_64);
            r_neg   <= w_sign1 ^ w_sign2;
            r_int32 <= int_32_i;
            r_op    <= op_i;
          end
        end
        OP: begin
          if (!kill_mul_i) begin
            {r_hi, r_lo} <= {w_sum, r_lo[63:1]};
            r_count      <= r_count - 7'd1;
          end
        end
        FIX: begin
          if (!kill_mul_i && r_neg) begin
            {r_hi, r_lo} <= ~{r_hi, r_lo} + 128'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // After 32 steps the 32-bit product sits in r_lo[63:32], not at the bottom.
  always_comb begin
    w_result = '0;
    if (w_done) begin
      if (r_int32) begin
        w_result = {{32{r_lo[63]}}, r_lo[63:32]};
      end else if (r_op == MUL) begin
        w_result = r_lo;
      end else begin
        w_result = r_hi;
      end
    end
  end

  assign stall_o     = w_stall && rstn_i;
  assign done_tick_o = w_done;
  assign result_o    = w_result;

endmodule

// File: doc/mul_iter_unit.md
MUL_ITER_UNIT -- requirements
Module: mul_iter_unit

Interface
REQ-001 The block SHALL have these ports: clk_i  in  1  core clock, rising edge.
REQ-002 The block SHALL have these ports: rstn_i  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-003 The block SHALL have these ports: kill_mul_i  in  1  flush; aborts any in-flight operation.
REQ-004 The block SHALL have these ports: request_i  in  1  start operation (sampled in IDLE only).
REQ-005 The block SHALL have these ports: int_32_i  in  1  RV64 W-variant (MULW).
REQ-006 The block SHALL have these ports: op_i  in  2  mul_op_t: MUL, MULH, MULHSU, MULHU.
REQ-007 The block SHALL have these ports: src1_i, src2_i  in  64 each  multiplicand rs1 and multiplier rs2.
REQ-008 The block SHALL have these ports: result_o  out  64  result, valid only while done_tick_o=1.
REQ-009 The block SHALL have these ports: stall_o  out  1  operation in flight.
REQ-010 The block SHALL have these ports: done_tick_o  out  1  one-cycle completion pulse.

Function
REQ-011 FSM states SHALL be IDLE, OP, FIX and DONE; any undefined encoding SHALL go to IDLE.
REQ-012 IDLE with request_i=1 and kill_mul_i=0 (cycle 0): the block SHALL assert stall_o, register src1_i, src2_i, op_i and int_32_i, and go to OP.
REQ-013 Operand registration SHALL work as follows:
- Operands are used as magnitudes.
- src1 is signed for MULH and MULHSU; src2 is signed for MULH.
- neg_q = sign1 ^ sign2, counting only the operands treated as signed.
REQ-014 In int_32 mode, only bits [31:0] SHALL be used, always as MUL; op_i SHALL be ignored.
REQ-015 OP SHALL perform one radix-2 shift-add step per cycle using a 65-bit add that keeps the carry.
- Iteration count N: 64, or 32 when int_32.
- OP lasts cycles 1..N, with stall_o=1 throughout.
REQ-016 After the last iteration, OP SHALL go to FIX; the accumulator then SHALL hold the unsigned product |a|*|b|.
REQ-017 FIX (cycle N+1) SHALL two's-complement negate the 128-bit product when neg_q=1, keep stall_o=1, and go to DONE.
REQ-018 DONE (cycle N+2) SHALL drive stall_o=0 and done_tick_o=1, then go to IDLE.
- result_o = product[63:0] for MUL.
- result_o = product[127:64] for MULH, MULHSU and MULHU.
- For int_32: result_o = sign-extension of product[31:0].
REQ-019 Latency from acceptance to done_tick_o SHALL be 66 cycles for 64-bit operations and 34 cycles for int_32.
REQ-020 result_o SHALL be 0 whenever done_tick_o=0.
REQ-021 request_i SHALL be ignored outside IDLE; inputs may change freely after acceptance without affecting the result.
REQ-022 kill_mul_i=1 in OP, FIX or DONE SHALL cause the following:
- next state IDLE;
- stall_o=0 and done_tick_o=0 in that cycle;
- no result is produced.
REQ-023 kill_mul_i=1 together with request_i in IDLE SHALL not start an operation.
REQ-024 A new request_i in the cycle after DONE or after a kill SHALL be accepted normally.
REQ-025 Zero operands SHALL take the full N iterations; the block SHALL NOT terminate early.

Reset
REQ-026 While rstn_i=0, the following SHALL hold regardless of clock:
- state = IDLE;
- all datapath registers = 0;
- stall_o = 0, done_tick_o = 0, result_o = 0.
REQ-027 Reset asserted during an operation SHALL abandon it with no done_tick_o after release.

Structure
REQ-028 The mul_op_t enum and the constants MUL_ITER_64=64 and MUL_ITER_32=32 SHALL live in drac_pkg.
REQ-029 The block SHALL be a single module with the add/shift step inline; it needs no sub-module.

Verification
REQ-030 MUL 64-bit, src1=3, src2=5 -> result_o=15 with done_tick_o at cycle 66; stall_o high during cycles 0-65.
REQ-031 MULH, 0x8000000000000000 x 0x8000000000000000 -> 0x4000000000000000.
REQ-032 MULH, -1 x -1 -> 0.
REQ-033 MULHU, 0xFFFFFFFFFFFFFFFF x 0xFFFFFFFFFFFFFFFF -> 0xFFFFFFFFFFFFFFFE.
REQ-034 MULHSU, src1=-1, src2=2 -> 0xFFFFFFFFFFFFFFFF.
REQ-035 MUL int_32, 0x7FFFFFFF x 2 -> 0xFFFFFFFFFFFFFFFE with done_tick_o at cycle 34.
REQ-036 Kill at cycle 10 -> stall_o=0 at cycle 10 and no done_tick_o.
- A request at cycle 11 with 7 x 6 -> 42 at cycle 77.
- rstn_i pulsed at cycle 20 of another operation -> IDLE, with no done_tick_o.
